// File: rtl/ex_muldiv_unit_if.sv
// Handshake/result bundle between the EX-stage pipeline and ex_muldiv_unit.
// master = pipeline side (issues operations), slave = multiply/divide unit.
interface ex_muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers for the EX stage.
// MULT/MULTU: radix-2 shift-add; DIV/DIVU: restoring division; MTHI/MTLO: direct write.
// Optional macro MULDIV_FAST_MUL_EN: MULT/MULTU use a single-cycle combinational
// multiplier whose result is registered one edge after issue.
module ex_muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    ex_muldiv_unit_if.slave mdu
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] p_hi_q, p_lo_q;  // product / remainder : multiplier / quotient
    logic [WIDTH-1:0] opnd_q;          // multiplicand or divisor magnitude
    logic [CW-1:0]    cnt_q;
    logic             done_q, div_q, raw_q, neg_q, rneg_q;

    // Issue decode and operand magnitudes
    logic             accept, is_mul, is_div, sgn, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign accept = (state_q == IDLE) && mdu.start && !mdu.flush;
    assign is_mul = (mdu.op[2:1] == 2'b00);
    assign is_div = (mdu.op[2:1] == 2'b01);
    assign sgn    = ~mdu.op[0];
    assign a_neg  = sgn & mdu.a[WIDTH-1];
    assign b_neg  = sgn & mdu.b[WIDTH-1];
    assign a_mag  = a_neg ? -mdu.a : mdu.a;
    assign b_mag  = b_neg ? -mdu.b : mdu.b;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{a_neg}}, mdu.a} * {{WIDTH{b_neg}}, mdu.b};
`endif

    // One iteration step plus final sign correction of the result
    logic [WIDTH:0]     m_sum, d_sh, d_diff;
    logic [WIDTH-1:0]   s_hi, s_lo, r_hi, r_lo;
    logic [2*WIDTH-1:0] prod;
    logic               last;

    assign last = raw_q || (cnt_q == CW'(WIDTH - 1));

    // Datapath step: shift-add for multiply, restoring subtract for divide
    always_comb begin
        m_sum  = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, opnd_q} : '0);
        d_sh   = {p_hi_q, p_lo_q[WIDTH-1]};
        d_diff = d_sh - {1'b0, opnd_q};
        s_hi   = m_sum[WIDTH:1];
        s_lo   = {m_sum[0], p_lo_q[WIDTH-1:1]};
        if (div_q) begin
            if (d_diff[WIDTH]) begin
                s_hi = d_sh[WIDTH-1:0];
                s_lo = {p_lo_q[WIDTH-2:0], 1'b0};
            end else begin
                s_hi = d_diff[WIDTH-1:0];
                s_lo = {p_lo_q[WIDTH-2:0], 1'b1};
            end
        end
        prod = {s_hi, s_lo};
        r_hi = s_hi;
        r_lo = s_lo;
        if (raw_q) begin
            r_hi = p_hi_q;
            r_lo = p_lo_q;
        end else if (div_q) begin
            // Most-negative / -1 yields magnitude 2^(WIDTH-1) with positive sign,
            // which already reads back as the most-negative value with zero remainder.
            r_lo = neg_q ? -s_lo : s_lo;
            r_hi = rneg_q ? -s_hi : s_hi;
        end else begin
            prod = neg_q ? -prod : prod;
            r_hi = prod[2*WIDTH-1:WIDTH];
            r_lo = prod[WIDTH-1:0];
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state: multiply/divide enter RUN, finish or flush return to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && (is_mul || is_div)) state_d = RUN;
            RUN:  if (mdu.flush || last)            state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand latch at issue, iteration in RUN, HI/LO write and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            p_hi_q <= '0;
            p_lo_q <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            div_q  <= 1'b0;
            raw_q  <= 1'b0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (accept) begin
                    cnt_q <= '0;
                    case (mdu.op)
                        3'd4:    hi_q <= mdu.a;
                        3'd5:    lo_q <= mdu.a;
                        default: ;
                    endcase
                    if (is_div) begin
                        div_q  <= 1'b1;
                        neg_q  <= a_neg ^ b_neg;
                        rneg_q <= a_neg;
                        opnd_q <= b_mag;
                        if (mdu.b == '0) begin
                            raw_q  <= 1'b1;
                            p_hi_q <= mdu.a;
                            p_lo_q <= '1;
                        end else begin
                            raw_q  <= 1'b0;
                            p_hi_q <= '0;
                            p_lo_q <= a_mag;
                        end
                    end else if (is_mul) begin
                        div_q  <= 1'b0;
                        neg_q  <= a_neg ^ b_neg;
                        rneg_q <= 1'b0;
                        opnd_q <= a_mag;
`ifdef MULDIV_FAST_MUL_EN
                        raw_q  <= 1'b1;
                        {p_hi_q, p_lo_q} <= fast_prod;
`else
                        raw_q  <= 1'b0;
                        p_hi_q <= '0;
                        p_lo_q <= b_mag;
`endif
                    end
                end
            end else if (!mdu.flush) begin
                p_hi_q <= s_hi;
                p_lo_q <= s_lo;
                cnt_q  <= cnt_q + CW'(1);
                if (last) begin
                    hi_q   <= r_hi;
                    lo_q   <= r_lo;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign mdu.busy = (state_q == RUN);
    assign mdu.done = done_q;
    assign mdu.hi   = hi_q;
    assign mdu.lo   = lo_q;
endmodule
